// File: rtl/mem_responder.sv
// mem_responder: single-request memory responder with wait states, word RAM, LED register and cycle counter
module mem_responder #(
  parameter int WORDS   = 256,
  parameter int LATENCY = 1,
  parameter int IO_BIT  = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [4:0]  leds
);
  localparam int AW = $clog2(WORDS);
  localparam logic [3:0] CNT0 = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [31:0] ram [WORDS];
  logic [31:0] pend_q, ctr, rd_val;
  logic [3:0]  cnt;
  logic        rd_q, req, io, unused;
  logic [AW-1:0] idx;
  always_comb begin
    req    = state == IDLE && (mem_rstrb || mem_wmask != 4'b0);
    io     = mem_addr[IO_BIT];
    idx    = mem_addr[AW+1:2];
    unused = ^mem_addr;
    rd_val = !io ? ram[idx] :
             mem_addr[3:2] == 2'd0 ? {27'b0, leds} :
             mem_addr[3:2] == 2'd1 ? ctr : 32'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req ? (LATENCY == 0 ? RESP : WAIT) : IDLE) :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  always_comb begin
    mem_busy = state != IDLE;
    mem_done = state == RESP;
  end
  // read data is sampled at accept so a combined read+write returns the old word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= 4'd0;
      rd_q      <= 1'b0;
      pend_q    <= 32'b0;
      mem_rdata <= 32'b0;
      leds      <= 5'b0;
      ctr       <= 32'b0;
    end else begin
      ctr <= ctr + 32'd1;
      if (req) begin
        cnt    <= CNT0;
        rd_q   <= mem_rstrb;
        pend_q <= rd_val;
        if (io && mem_addr[3:2] == 2'd0 && mem_wmask[0]) leds <= mem_wdata[4:0];
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (req && LATENCY == 0 && mem_rstrb) mem_rdata <= rd_val;
      else if (state == WAIT && cnt == 4'd0 && rd_q) mem_rdata <= pend_q;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (req && !io && mem_wmask[i]) ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a timeline model
module tb_mem_responder;
  localparam int LAT = 4, WORDS = 256, IOB = 22;
  localparam logic [31:0] IO = 32'h1 << IOB;
  logic clk = 0, rst = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0]  mem_wmask = 0;
  logic        mem_rstrb = 0, mem_busy, mem_done;
  logic [4:0]  leds;
  int tests = 0, fails = 0, cyc = 0;

  mem_responder #(.WORDS(WORDS), .LATENCY(LAT), .IO_BIT(IOB)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .mem_done(mem_done), .leds(leds));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: a request lives for LAT+1 edges after its accept edge; done in the last one
  logic [31:0] ram_m [WORDS];
  logic [31:0] rdata_m = 0, pend_m = 0, ctr_m = 0;
  logic [4:0]  leds_m = 0;
  int age = 0;
  bit inflight = 0, rd_m = 0;
  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      inflight = 0; rdata_m = 0; ctr_m = 0; leds_m = 0;
    end else begin
      if (inflight) begin
        if (age == LAT) inflight = 0;
        else begin
          age++;
          if (age == LAT && rd_m) rdata_m = pend_m;
        end
      end else if (mem_rstrb || mem_wmask != 0) begin
        w = int'(mem_addr[9:2]);
        if (mem_addr[IOB])
          pend_m = mem_addr[3:2] == 0 ? {27'b0, leds_m} : mem_addr[3:2] == 1 ? ctr_m : 32'b0;
        else
          pend_m = ram_m[w];
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b] && !mem_addr[IOB]) ram_m[w][8*b +: 8] = mem_wdata[8*b +: 8];
        if (mem_addr[IOB] && mem_addr[3:2] == 0 && mem_wmask[0]) leds_m = mem_wdata[4:0];
        inflight = 1; age = 0; rd_m = mem_rstrb;
        if (LAT == 0 && rd_m) rdata_m = pend_m;
      end
      ctr_m++;
    end
  end

  always @(negedge clk)
    if (!rst) begin
      check("busy", {31'b0, mem_busy}, {31'b0, inflight});
      check("done", {31'b0, mem_done}, {31'b0, inflight && age == LAT});
      check("leds", {27'b0, leds}, {27'b0, leds_m});
      check("rdata", mem_rdata, rdata_m);
    end

  task automatic wait_idle();
    int n = 0;
    while (mem_busy && n < 50) begin @(negedge clk); n++; end
    if (mem_busy) check("idle_timeout", {31'b0, mem_busy}, 0);
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                     input logic r, output logic [31:0] q, output int t);
    int n;
    wait_idle();
    mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = r;
    @(negedge clk);
    t = cyc;
    mem_wmask = 0; mem_rstrb = 0;
    n = 1;
    while (!mem_done && n < 40) begin @(negedge clk); n++; end
    check("latency", n, LAT + 1);
    q = mem_rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q, q2;
    int t1, t2, nd;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, mem_busy}, 0);
    check("rst_done", {31'b0, mem_done}, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_leds", {27'b0, leds}, 0);
    rst = 0;
    for (int i = 0; i < WORDS; i++) req(32'(i * 4), $urandom, 4'hF, 0, q, t1);
    req(32'h10, 32'hDEADBEEF, 4'hF, 0, q, t1);
    req(32'h10, 0, 0, 1, q, t1);
    check("t1_read", q, 32'hDEADBEEF);
    req(32'h10, 32'h000000AA, 4'b0001, 0, q, t1);
    req(32'h10, 32'h55000000, 4'b1000, 0, q, t1);
    req(32'h10, 0, 0, 1, q, t1);
    check("t2_mask", q, 32'h55ADBEAA);
    req(32'h400, 32'h1234, 4'hF, 0, q, t1);
    req(32'h0, 0, 0, 1, q, t1);
    check("t3_wrap", q, 32'h1234);
    req(IO, 32'h1F, 4'h1, 0, q, t1);
    check("t4_leds", {27'b0, leds}, 32'h1F);
    req(IO | 32'h0, 0, 0, 1, q, t1);
    check("t4_ledread", q, 32'h1F);
    req(IO | 32'h4, 0, 0, 1, q, t1);
    repeat ($urandom_range(3, 20)) @(negedge clk);
    req(IO | 32'h4, 0, 0, 1, q2, t2);
    check("t4_ctr_delta", q2 - q, 32'(t2 - t1));
    req(IO | 32'h8, 0, 0, 1, q, t1);
    check("t4_io_off2", q, 0);
    wait_idle();
    mem_addr = 32'h10; mem_rstrb = 1;
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      mem_addr = 32'h20;
      mem_rstrb = (i == 1 || i == LAT);
      @(negedge clk);
      nd += int'(mem_done);
    end
    mem_rstrb = 0;
    check("t5_one_done", nd, 1);
    req(32'h30, 7, 4'hF, 0, q, t1);
    req(32'h30, 9, 4'hF, 1, q, t1);
    check("t5_rbw_old", q, 7);
    req(32'h30, 0, 0, 1, q, t1);
    check("t5_rbw_new", q, 9);
    req(32'h44, 32'hCAFEF00D, 4'hF, 0, q, t1);
    wait_idle();
    mem_addr = 32'h48; mem_wdata = 32'h0BADBEEF; mem_wmask = 4'hF;
    @(negedge clk);
    mem_wmask = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("t6_busy", {31'b0, mem_busy}, 0);
    check("t6_done", {31'b0, mem_done}, 0);
    check("t6_leds", {27'b0, leds}, 0);
    check("t6_rdata", mem_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (LAT + 4) begin @(negedge clk); nd += int'(mem_done); end
    check("t6_no_done", nd, 0);
    req(32'h48, 0, 0, 1, q, t1);
    check("t6_committed", q, 32'h0BADBEEF);
    req(32'h44, 0, 0, 1, q, t1);
    check("t6_prior", q, 32'hCAFEF00D);
    for (int i = 0; i < 3000; i++) begin
      mem_addr = $urandom;
      mem_addr[IOB] = ($urandom % 4 == 0);
      mem_wdata = $urandom;
      mem_wmask = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      mem_rstrb = ($urandom % 3 == 0);
      @(negedge clk);
    end
    mem_wmask = 0; mem_rstrb = 0;
    wait_idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
